// File: rtl/add_arb_pkg.sv
// Shared configuration for the add_arb slice: default widths, stage records and the id-width helper.
// Optional build macro: ADD_ARB_PRIO_EN (fixed priority for requester 0).
package add_arb_pkg;

  localparam int XLEN = 32;
  localparam int NREQ = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(NREQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            op;
    logic [XLEN-1:0] data0;
    logic [XLEN-1:0] data1;
  } s1_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] result;
  } s2_t;

endpackage

// File: rtl/add_arb_add.sv
// Combinational add/subtract unit; the result wraps modulo 2^XLEN and has no carry out.
module add #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data0,
  input  logic [XLEN-1:0] data1,
  input  logic            op,
  output logic [XLEN-1:0] result
);

  assign result = op ? (data0 - data1) : (data0 + data1);

endmodule

// File: rtl/add_arb_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after ptr (wrapping) receives a one-hot grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arb.sv
// Shares one add unit among NREQ requesters through a two-stage pipeline with round-robin grant.
// Build macro ADD_ARB_PRIO_EN gives requester 0 absolute priority over the rotating pointer.
module add_arb
  import add_arb_pkg::*;
#(
  parameter int XLEN = add_arb_pkg::XLEN,
  parameter int NREQ = add_arb_pkg::NREQ,
  localparam int IDW = id_width(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*XLEN-1:0] req_data0,
  input  logic [NREQ*XLEN-1:0] req_data1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_result
);

  typedef struct packed {
    logic            valid;
    logic [IDW-1:0]  id;
    logic            op;
    logic [XLEN-1:0] data0;
    logic [XLEN-1:0] data1;
  } s1_stage_t;

  typedef struct packed {
    logic            valid;
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] result;
  } s2_stage_t;

  s1_stage_t       s1;
  s2_stage_t       s2;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] rr_req;
  logic [NREQ-1:0] rr_grant;
  logic [NREQ-1:0] grant;
  logic [XLEN-1:0] sum;
  logic            stall;
  logic            accept;
  logic            take;

  assign stall  = s2.valid & ~rsp_ready;
  assign accept = ~s1.valid | ~stall;

`ifdef ADD_ARB_PRIO_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign rr_req = req_valid & ~NREQ'(1);
  assign grant  = req_valid[0] ? NREQ'(1) : rr_grant;
`else
  assign rr_req = req_valid;
  assign grant  = rr_grant;
`endif

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req  (rr_req),
    .ptr  (ptr),
    .grant(rr_grant)
  );

  add #(
    .XLEN(XLEN)
  ) u_add (
    .data0 (s1.data0),
    .data1 (s1.data1),
    .op    (s1.op),
    .result(sum)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_id = IDW'(i);
    end
  end

  assign take      = accept & (|grant) & ~reset;
  assign req_ready = take ? grant : '0;

  // Pointer moves just past the winner; with priority enabled it never rests on requester 0.
  always_comb begin
    ptr_next = ptr;
    if (take) begin
      ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
`ifdef ADD_ARB_PRIO_EN
      if (NREQ > 1) begin
        if (gnt_id == '0) ptr_next = (ptr == '0) ? IDW'(1) : ptr;
        else if (ptr_next == '0) ptr_next = IDW'(1);
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1  <= '0;
      s2  <= '0;
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
      if (accept) begin
        s1.valid <= take;
        if (take) begin
          s1.id    <= gnt_id;
          s1.op    <= req_op[gnt_id];
          s1.data0 <= req_data0[gnt_id*XLEN +: XLEN];
          s1.data1 <= req_data1[gnt_id*XLEN +: XLEN];
        end
      end
      // S2 data only changes when a real operation moves in, keeping outputs quiet otherwise.
      if (!stall) begin
        s2.valid <= s1.valid;
        if (s1.valid) begin
          s2.id     <= s1.id;
          s2.result <= sum;
        end
      end
    end
  end

  assign rsp_valid  = s2.valid;
  assign rsp_id     = s2.id;
  assign rsp_result = s2.result;

endmodule

// File: tb/tb_add_arb.sv
// Self-checking bench for add_arb: directed scenarios then random traffic against a queue-based model.
module tb_add_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_data0;
  logic [N*W-1:0] req_data1;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;

  add_arb #(.XLEN(W), .NREQ(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    int           age;
  } item_t;

  item_t        q[$];
  int           ptr;
  int           checks;
  int           errors;
  bit           pend[N];
  bit           op_m[N];
  logic [W-1:0] a_m[N];
  logic [W-1:0] b_m[N];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic newOp(input int i, input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1;
    op_m[i] = op;
    a_m[i]  = a;
    b_m[i]  = b;
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom % 4)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // One cycle: drive at the falling edge, compare shortly after, then advance the model on the rising edge.
  task automatic applyStimulus(input bit rr, input bit rst);
    int           g;
    bit           exp_valid;
    logic [N-1:0] exp_ready;
    reset     = rst;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_op[i]              = op_m[i];
      req_data0[i*W +: W]    = a_m[i];
      req_data1[i*W +: W]    = b_m[i];
    end
    #1;
    g = -1;
    if (!rst && (q.size() < 2 || rr)) begin
`ifdef ADD_ARB_PRIO_EN
      if (pend[0]) g = 0;
      else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (ptr + k) % N;
          if (g < 0 && i != 0 && pend[i]) g = i;
        end
      end
`else
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (g < 0 && pend[i]) g = i;
      end
`endif
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    exp_valid = (q.size() > 0) && (q[0].age >= 1);
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(q[0].id));
      checkOutput("rsp_result", rsp_result, q[0].res);
    end
    @(posedge clock);
    if (rst) begin
      q.delete();
      ptr = 0;
    end else begin
      if (exp_valid && rr) void'(q.pop_front());
      foreach (q[j]) q[j].age++;
      if (g >= 0) begin
        item_t it;
        it.id  = g;
        it.res = op_m[g] ? (a_m[g] - b_m[g]) : (a_m[g] + b_m[g]);
        it.age = 0;
        q.push_back(it);
        pend[g] = 1'b0;
`ifdef ADD_ARB_PRIO_EN
        if (g == 0) ptr = (ptr == 0) ? 1 : ptr;
        else ptr = ((g + 1) % N == 0) ? 1 : (g + 1) % N;
`else
        ptr = (g + 1) % N;
`endif
      end
    end
    @(negedge clock);
  endtask

  task automatic refillAll();
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) newOp(i, 1'($urandom % 2), randOperand(), randOperand());
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ptr       = 0;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_data0 = '0;
    req_data1 = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      op_m[i] = 1'b0;
      a_m[i]  = '0;
      b_m[i]  = '0;
    end
    @(negedge clock);

    // Reset state
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_result", rsp_result, 32'd0);

    // Single request from requester 2: 5 + 3
    newOp(2, 1'b0, 32'h0000_0005, 32'h0000_0003);
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, 1'b0);

    // All requesters busy with rsp_ready high
    for (int s = 0; s < 10; s++) begin
      refillAll();
      applyStimulus(1'b1, 1'b0);
    end
    for (int s = 0; s < 3; s++) applyStimulus(1'b1, 1'b0);

    // Wrap-around boundaries
    newOp(0, 1'b1, 32'h0000_0000, 32'h0000_0001);
    newOp(1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    for (int s = 0; s < 5; s++) applyStimulus(1'b1, 1'b0);

    // Back-pressure with both stages full, then drain
    refillAll();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int s = 0; s < 3; s++) applyStimulus(1'b0, 1'b0);
    for (int s = 0; s < 8; s++) applyStimulus(1'b1, 1'b0);

    // Reset with two operations in flight
    refillAll();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int s = 0; s < 5; s++) applyStimulus(1'b1, 1'b0);

    // Random traffic, back-pressure and occasional reset
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) newOp(i, 1'($urandom % 2), randOperand(), randOperand());
      end
      applyStimulus(($urandom % 4) != 0, ($urandom % 64) == 0);
    end
    for (int s = 0; s < 8; s++) applyStimulus(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
